// File: rtl/nn_pkg.sv
// Shared fixed-point constants and state types for the classifier datapath blocks.
package nn_pkg;

  localparam int unsigned NN_WIDTH = 16;
  localparam int unsigned NN_FRAC  = 8;

  // Q8.8 reference points used by the layer blocks
  localparam logic signed [NN_WIDTH-1:0] NN_Q_ONE = NN_WIDTH'(1 << NN_FRAC);
  localparam logic signed [NN_WIDTH-1:0] NN_Q_MAX = {1'b0, {(NN_WIDTH-1){1'b1}}};
  localparam logic signed [NN_WIDTH-1:0] NN_Q_MIN = {1'b1, {(NN_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/argmax_serial.sv
// Serial argmax over one captured logit vector: one element compared per cycle,
// result held on a valid/ready output until retired.
module argmax_serial
  import nn_pkg::*;
#(
  parameter int unsigned DIM   = 10,
  parameter int unsigned WIDTH = NN_WIDTH,
  parameter int unsigned FRAC  = NN_FRAC,
  localparam int unsigned IDX_W = (DIM > 1) ? $clog2(DIM) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] in_vec,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic [WIDTH-1:0]     out_val,
  output logic                 busy
);

  // Fixed-point position does not affect ordering of two's complement values
  localparam int unsigned frac_unused = FRAC;

  localparam argmax_state_t FIRST_STATE = (DIM >= 2) ? SCAN : DONE;

  argmax_state_t        state;
  argmax_state_t        next_state;
  logic [DIM*WIDTH-1:0] vec;
  logic [IDX_W-1:0]     cnt;
  logic [IDX_W-1:0]     best_idx;
  logic [WIDTH-1:0]     best_val;
  logic [WIDTH-1:0]     cur_elem;
  logic                 is_last;
  logic                 greater;
  logic                 accept;

  assign cur_elem = vec[cnt*WIDTH +: WIDTH];
  assign is_last  = (cnt == IDX_W'(DIM - 1));
  assign greater  = $signed(cur_elem) > $signed(best_val);

  // Handshake and next-state decode
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    accept     = 1'b0;

    in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    accept   = in_valid && in_ready;

    case (state)
      IDLE: if (accept) next_state = FIRST_STATE;
      SCAN: if (is_last) next_state = DONE;
      DONE: if (out_ready) next_state = accept ? FIRST_STATE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State, scan datapath and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      cnt       <= '0;
      best_idx  <= '0;
      best_val  <= '0;
      out_idx   <= '0;
      out_val   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= next_state;
      out_valid <= (next_state == DONE);
      busy      <= (next_state != IDLE);

      if (accept) begin
        vec      <= in_vec;
        best_val <= in_vec[WIDTH-1:0];
        best_idx <= '0;
        cnt      <= IDX_W'(1);
        // Single-element vectors skip the scan and publish element 0 directly
        if (FIRST_STATE == DONE) begin
          out_idx <= '0;
          out_val <= in_vec[WIDTH-1:0];
        end
      end else if (state == SCAN) begin
        if (greater) begin
          best_val <= cur_elem;
          best_idx <= cnt;
        end
        // Last compare folds straight into the output registers
        if (is_last) begin
          out_idx <= greater ? cnt : best_idx;
          out_val <= greater ? cur_elem : best_val;
        end else begin
          cnt <= cnt + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_argmax_serial.sv
// Directed bench for argmax_serial: DIM=4 and DIM=1 instances sharing clock and reset.
module tb_argmax_serial;

  logic        clk;
  logic        rst;

  logic        in_valid4;
  logic        in_ready4;
  logic [63:0] in_vec4;
  logic        out_valid4;
  logic        out_ready4;
  logic [1:0]  out_idx4;
  logic [15:0] out_val4;
  logic        busy4;

  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] in_vec1;
  logic        out_valid1;
  logic        out_ready1;
  logic [0:0]  out_idx1;
  logic [15:0] out_val1;
  logic        busy1;

  int n_checks;
  int n_fail;

  argmax_serial #(.DIM(4), .WIDTH(16), .FRAC(8)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_vec    (in_vec4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_idx   (out_idx4),
    .out_val   (out_val4),
    .busy      (busy4)
  );

  argmax_serial #(.DIM(1), .WIDTH(16), .FRAC(8)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .in_vec    (in_vec1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .out_idx   (out_idx1),
    .out_val   (out_val1),
    .busy      (busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one vector to the DIM=4 instance, then count edges until out_valid
  task automatic send4(input logic [63:0] v, output int lat);
    @(negedge clk);
    in_vec4   = v;
    in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic retire4();
    @(negedge clk);
    out_ready4 = 1'b1;
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid4 = 1'b0; in_vec4 = '0; out_ready4 = 1'b0;
    in_valid1 = 1'b0; in_vec1 = '0; out_ready1 = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid4 !== 1'b0 || busy4 !== 1'b0 || in_ready4 !== 1'b0) begin
      $display("FAIL reset_ctrl: got valid=%b busy=%b rdy=%b expected 0 0 0", out_valid4, busy4, in_ready4);
      n_fail++;
    end
    n_checks++;
    if (out_idx4 !== 2'd0 || out_val4 !== 16'h0000) begin
      $display("FAIL reset_data: got idx=%0d val=%h expected 0 0000", out_idx4, out_val4);
      n_fail++;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready4 !== 1'b1 || in_ready1 !== 1'b1) begin
      $display("FAIL reset_release_ready: got %b/%b expected 1/1", in_ready4, in_ready1);
      n_fail++;
    end
  endtask

  task automatic test_basic_max();
    int lat;
    send4({16'h0200, 16'hFF00, 16'h0300, 16'h0100}, lat);
    n_checks++;
    if (lat !== 3) begin
      $display("FAIL basic_latency: got %0d expected 3", lat);
      n_fail++;
    end
    n_checks++;
    if (out_idx4 !== 2'd1 || out_val4 !== 16'h0300) begin
      $display("FAIL basic_result: got idx=%0d val=%h expected 1 0300", out_idx4, out_val4);
      n_fail++;
    end
    retire4();
    n_checks++;
    if (out_valid4 !== 1'b0 || busy4 !== 1'b0) begin
      $display("FAIL basic_retire: got valid=%b busy=%b expected 0 0", out_valid4, busy4);
      n_fail++;
    end
  endtask

  task automatic test_signed_negative();
    int lat;
    send4({16'hFE00, 16'hFFFF, 16'h8000, 16'hFF00}, lat);
    n_checks++;
    if (lat !== 3 || out_idx4 !== 2'd2 || out_val4 !== 16'hFFFF) begin
      $display("FAIL signed_neg: got lat=%0d idx=%0d val=%h expected 3 2 ffff", lat, out_idx4, out_val4);
      n_fail++;
    end
    retire4();
  endtask

  task automatic test_ties();
    int lat;
    send4({16'h0500, 16'h0100, 16'h0500, 16'h0500}, lat);
    n_checks++;
    if (lat !== 3 || out_idx4 !== 2'd0 || out_val4 !== 16'h0500) begin
      $display("FAIL ties_lowest: got lat=%0d idx=%0d val=%h expected 3 0 0500", lat, out_idx4, out_val4);
      n_fail++;
    end
    retire4();
  endtask

  task automatic test_back_to_back();
    int lat;
    send4({16'h0200, 16'hFF00, 16'h0300, 16'h0100}, lat);
    n_checks++;
    if (lat !== 3) begin
      $display("FAIL b2b_first_latency: got %0d expected 3", lat);
      n_fail++;
    end
    @(negedge clk);
    in_vec4   = {16'h0002, 16'h0000, 16'h0000, 16'h0001};
    in_valid4 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid4 !== 1'b1 || out_idx4 !== 2'd1 || out_val4 !== 16'h0300 || in_ready4 !== 1'b0) begin
        $display("FAIL hold_stable[%0d]: got v=%b idx=%0d val=%h rdy=%b expected 1 1 0300 0",
                 i, out_valid4, out_idx4, out_val4, in_ready4);
        n_fail++;
      end
    end
    @(negedge clk);
    out_ready4 = 1'b1;
    #1;
    n_checks++;
    if (in_ready4 !== 1'b1) begin
      $display("FAIL b2b_ready: got %b expected 1", in_ready4);
      n_fail++;
    end
    @(posedge clk);
    #1;
    out_ready4 = 1'b0;
    in_valid4  = 1'b0;
    n_checks++;
    if (out_valid4 !== 1'b0 || busy4 !== 1'b1) begin
      $display("FAIL b2b_handoff: got valid=%b busy=%b expected 0 1", out_valid4, busy4);
      n_fail++;
    end
    lat = 0;
    while (out_valid4 !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_checks++;
    if (lat !== 3 || out_idx4 !== 2'd3 || out_val4 !== 16'h0002) begin
      $display("FAIL b2b_second: got lat=%0d idx=%0d val=%h expected 3 3 0002", lat, out_idx4, out_val4);
      n_fail++;
    end
    retire4();
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    @(negedge clk);
    in_vec4   = {16'h7000, 16'h0000, 16'h0000, 16'h0000};
    in_valid4 = 1'b1;
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy4 !== 1'b0 || out_valid4 !== 1'b0 || in_ready4 !== 1'b0) begin
      $display("FAIL midscan_reset: got busy=%b valid=%b rdy=%b expected 0 0 0", busy4, out_valid4, in_ready4);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready4 !== 1'b1) begin
      $display("FAIL midscan_release_ready: got %b expected 1", in_ready4);
      n_fail++;
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid4 !== 1'b0 || busy4 !== 1'b0) begin
      $display("FAIL midscan_no_stale: got valid=%b busy=%b expected 0 0", out_valid4, busy4);
      n_fail++;
    end
    send4({16'h8000, 16'h7FFF, 16'h0200, 16'h0100}, lat);
    n_checks++;
    if (lat !== 3 || out_idx4 !== 2'd2 || out_val4 !== 16'h7FFF) begin
      $display("FAIL midscan_next: got lat=%0d idx=%0d val=%h expected 3 2 7fff", lat, out_idx4, out_val4);
      n_fail++;
    end
    retire4();
  endtask

  task automatic test_dim1();
    @(negedge clk);
    in_vec1   = 16'h8000;
    in_valid1 = 1'b1;
    #1;
    n_checks++;
    if (in_ready1 !== 1'b1) begin
      $display("FAIL dim1_ready: got %b expected 1", in_ready1);
      n_fail++;
    end
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b1 || out_idx1 !== 1'b0 || out_val1 !== 16'h8000 || busy1 !== 1'b1) begin
      $display("FAIL dim1_result: got v=%b idx=%0d val=%h busy=%b expected 1 0 8000 1",
               out_valid1, out_idx1, out_val1, busy1);
      n_fail++;
    end
    @(negedge clk);
    out_ready1 = 1'b1;
    in_vec1    = 16'h7FFF;
    in_valid1  = 1'b1;
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    in_valid1  = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b1 || out_val1 !== 16'h7FFF) begin
      $display("FAIL dim1_b2b: got v=%b val=%h expected 1 7fff", out_valid1, out_val1);
      n_fail++;
    end
    @(negedge clk);
    out_ready1 = 1'b1;
    @(posedge clk);
    #1;
    out_ready1 = 1'b0;
    n_checks++;
    if (out_valid1 !== 1'b0 || busy1 !== 1'b0) begin
      $display("FAIL dim1_retire: got valid=%b busy=%b expected 0 0", out_valid1, busy1);
      n_fail++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_max();
    test_signed_negative();
    test_ties();
    test_back_to_back();
    test_reset_mid_scan();
    test_dim1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
